// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter that time-shares one 64-bit Brent-Kung adder (8-bit groups)
// between NREQ requesters; one operation in flight, result returned with its requester ID.
module adder_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 64,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH:0]        rsp_sum,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy,
    output logic [31:0]           op_count
);

    localparam int GS = 8;
    localparam int NG = WIDTH / GS;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_reg;
    logic [IDW-1:0]   rr_ptr_reg;
    logic [WIDTH-1:0] op_a_reg;
    logic [WIDTH-1:0] op_b_reg;
    logic [WIDTH:0]   sum_reg;
    logic [IDW-1:0]   id_reg;
    logic [31:0]      op_count_reg;

    logic [WIDTH-1:0] req_a_arr [NREQ];
    logic [WIDTH-1:0] req_b_arr [NREQ];
    logic [IDW-1:0]   grant;
    logic             grant_found;
    logic             accept_ok;
    logic [WIDTH:0]   adder_s;

    // Group generate/propagate ripple inside each 8-bit group; the group carries come
    // from a Brent-Kung prefix tree (up-sweep then down-sweep) over the groups.
    function automatic logic [WIDTH:0] bk_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [NG-1:0]    gg;
        logic [NG-1:0]    gp;
        logic [WIDTH:0]   c;
        g = a & b;
        p = a ^ b;
        gg = '0;
        gp = '1;
        c = '0;
        for (int k = 0; k < NG; k++) begin
            for (int j = 0; j < GS; j++) begin
                gg[k] = g[k*GS+j] | (p[k*GS+j] & gg[k]);
                gp[k] = p[k*GS+j] & gp[k];
            end
        end
        for (int d = 1; d < NG; d = d * 2) begin
            for (int i = 2*d-1; i < NG; i = i + 2*d) begin
                gg[i] = gg[i] | (gp[i] & gg[i-d]);
                gp[i] = gp[i] & gp[i-d];
            end
        end
        for (int d = NG/4; d >= 1; d = d / 2) begin
            for (int i = 3*d-1; i < NG; i = i + 2*d) begin
                gg[i] = gg[i] | (gp[i] & gg[i-d]);
                gp[i] = gp[i] & gp[i-d];
            end
        end
        for (int k = 0; k < NG; k++) begin
            c[k*GS] = (k == 0) ? 1'b0 : gg[k-1];
            for (int j = 0; j < GS; j++) begin
                c[k*GS+j+1] = g[k*GS+j] | (p[k*GS+j] & c[k*GS+j]);
            end
        end
        return {c[WIDTH], p ^ c[WIDTH-1:0]};
    endfunction

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
            assign req_a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign req_b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
            assign req_ready[gi] = accept_ok && (grant == IDW'(gi));
        end
    endgenerate

    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = (int'(rr_ptr_reg) + i) % NREQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant       = IDW'(idx);
            end
        end
    end

    assign accept_ok = rst_n && (state_reg == ST_IDLE) && grant_found;
    assign adder_s   = bk_add(op_a_reg, op_b_reg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            rr_ptr_reg   <= '0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            sum_reg      <= '0;
            id_reg       <= '0;
            op_count_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_found) begin
                        op_a_reg   <= req_a_arr[grant];
                        op_b_reg   <= req_b_arr[grant];
                        id_reg     <= grant;
                        rr_ptr_reg <= (grant == IDW'(NREQ-1)) ? '0 : grant + 1'b1;
                        state_reg  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    sum_reg   <= adder_s;
                    state_reg <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        op_count_reg <= op_count_reg + 32'd1;
                        state_reg    <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_sum   = sum_reg;
    assign rsp_id    = id_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign op_count  = op_count_reg;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Scoreboard bench for adder_share_arbiter: directed vectors plus a random phase
// checked against a small cycle model of the arbiter.
module tb_adder_share_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 64;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH:0]        rsp_sum;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;
    logic [31:0]           op_count;

    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];

    int total = 0;
    int bad   = 0;
    int hs_cnt = 0;
    logic [66:0] sb [$];

    bit rnd_on = 0;
    int m_state = 0;
    int m_rr = 0;

    assign req_a = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
    assign req_b = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

    adder_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_id(rsp_id),
        .busy(busy), .op_count(op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH:0] sum, input int id);
        sb.push_back({2'(id), sum});
    endtask

    // Monitor: pop and compare on every response handshake; model runs in the random phase.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            hs_cnt++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected got id=%0d sum=%h want=no response", rsp_id, rsp_sum);
            end else begin
                logic [66:0] e;
                e = sb.pop_front();
                check("rsp_sum", {2'b0, rsp_sum}, {2'b0, e[64:0]});
                check("rsp_id", {65'b0, rsp_id}, {65'b0, e[66:65]});
                $display("rsp id=%0d sum=%h", rsp_id, rsp_sum);
            end
        end
        if (rnd_on) begin
            if (!rst_n) begin
                m_state = 0;
                m_rr    = 0;
            end else begin
                case (m_state)
                    0: begin
                        logic [NREQ-1:0] er;
                        int g;
                        bit fnd;
                        er  = '0;
                        g   = 0;
                        fnd = 0;
                        for (int i = 0; i < NREQ; i++) begin
                            int k;
                            k = (m_rr + i) % NREQ;
                            if (!fnd && req_valid[k]) begin
                                fnd = 1;
                                g   = k;
                            end
                        end
                        if (fnd) er[g] = 1'b1;
                        check("rnd_req_ready", {63'b0, req_ready}, {63'b0, er});
                        if (fnd) begin
                            push({1'b0, a_arr[g]} + {1'b0, b_arr[g]}, g);
                            m_rr    = (g + 1) % NREQ;
                            m_state = 1;
                        end
                    end
                    1: m_state = 2;
                    default: if (rsp_ready) m_state = 0;
                endcase
            end
        end
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {66'b0, busy}, 67'd0);
        check("rst_rsp_valid", {66'b0, rsp_valid}, 67'd0);
        check("rst_op_count", {35'b0, op_count}, 67'd0);
        check("rst_req_ready", {63'b0, req_ready}, 67'd0);
        rst_n = 1'b1;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};
    int base;

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = '0;
            b_arr[i] = '0;
        end
        do_reset();

        // Single op: 5 + 7 from requester 0
        a_arr[0] = 64'h5; b_arr[0] = 64'h7;
        req_valid = 4'b0001; rsp_ready = 1'b1;
        push(65'h0C, 0);
        #1 check("single_ready", {63'b0, req_ready}, 67'b0001);
        cyc();
        req_valid = '0;
        check("single_busy_exec", {66'b0, busy}, 67'd1);
        check("single_no_rsp_t1", {66'b0, rsp_valid}, 67'd0);
        check("single_ready_exec", {63'b0, req_ready}, 67'd0);
        cyc();
        check("single_rsp_t2", {66'b0, rsp_valid}, 67'd1);
        cyc();
        check("single_idle_t3", {66'b0, rsp_valid}, 67'd0);
        check("single_op_count", {35'b0, op_count}, 67'd1);

        // Carry-out from requester 1
        a_arr[1] = 64'hFFFF_FFFF_FFFF_FFFF; b_arr[1] = 64'h1;
        req_valid = 4'b0010;
        push(65'h1_0000_0000_0000_0000, 1);
        #1 check("carry_ready", {63'b0, req_ready}, 67'b0010);
        cyc();
        req_valid = '0;
        cyc();
        check("carry_rsp", {66'b0, rsp_valid}, 67'd1);
        cyc();
        check("carry_op_count", {35'b0, op_count}, 67'd2);

        // Round robin with all four requesters valid from reset
        do_reset();
        a_arr[0] = 64'h10; b_arr[0] = 64'h1;
        a_arr[1] = 64'h20; b_arr[1] = 64'h2;
        a_arr[2] = 64'h30; b_arr[2] = 64'h3;
        a_arr[3] = 64'h8000_0000_0000_0000; b_arr[3] = 64'h8000_0000_0000_0000;
        push(65'h11, 0); push(65'h22, 1); push(65'h33, 2);
        push(65'h1_0000_0000_0000_0000, 3); push(65'h11, 0);
        req_valid = 4'b1111; rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            logic [NREQ-1:0] oh;
            oh = '0;
            oh[order[i]] = 1'b1;
            #1 check("rr_grant", {63'b0, req_ready}, {63'b0, oh});
            cyc();
            if (i == 4) req_valid = '0;
            cyc();
            cyc();
        end
        check("rr_op_count", {35'b0, op_count}, 67'd5);

        // Backpressure on requester 2 (rr_ptr now 1)
        a_arr[2] = 64'h1234; b_arr[2] = 64'h1111;
        push(65'h2345, 2); push(65'h2345, 2);
        rsp_ready = 1'b0; req_valid = 4'b0100;
        #1 check("bp_ready", {63'b0, req_ready}, 67'b0100);
        cyc();
        cyc();
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp_valid", {66'b0, rsp_valid}, 67'd1);
            check("bp_sum_stable", {2'b0, rsp_sum}, 67'h2345);
            check("bp_id_stable", {65'b0, rsp_id}, 67'd2);
            check("bp_ready_low", {63'b0, req_ready}, 67'd0);
            cyc();
        end
        rsp_ready = 1'b1;
        cyc();
        check("bp_reaccept", {63'b0, req_ready}, 67'b0100);
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        check("bp_op_count", {35'b0, op_count}, 67'd7);

        // Reset during EXEC (rr_ptr now 3)
        a_arr[3] = 64'h99; b_arr[3] = 64'h1;
        req_valid = 4'b1000;
        cyc();
        check("mid_busy_exec", {66'b0, busy}, 67'd1);
        rst_n = 1'b0; req_valid = 4'b1111;
        #1 check("mid_ready_in_reset", {63'b0, req_ready}, 67'd0);
        cyc();
        rst_n = 1'b1;
        #1;
        check("mid_no_rsp", {66'b0, rsp_valid}, 67'd0);
        check("mid_op_count", {35'b0, op_count}, 67'd0);
        check("mid_rr_reset", {63'b0, req_ready}, 67'b0001);
        push(65'h11, 0);
        cyc();
        req_valid = '0;
        cyc();
        cyc();
        check("mid_op_count_after", {35'b0, op_count}, 67'd1);

        // Random phase against the cycle model
        do_reset();
        m_state = 0; m_rr = 0; base = hs_cnt;
        rnd_on = 1;
        for (int n = 0; n < 6000; n++) begin
            req_valid = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                a_arr[i] = {$urandom, $urandom};
                b_arr[i] = {$urandom, $urandom};
            end
            cyc();
        end
        req_valid = '0; rsp_ready = 1'b1;
        repeat (5) cyc();
        rnd_on = 0;
        check("rnd_op_count", {35'b0, op_count}, 67'(hs_cnt - base));
        check("sb_empty", 67'(sb.size()), 67'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
